// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with shadowed display data.
// Optional leading-zero suppression is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_driver #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   data,
  input  logic [N_DIGITS-1:0]     points,
  input  logic [N_DIGITS-1:0]     blank,
  output logic [7:0]              seg,
  output logic [N_DIGITS-1:0]     an
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [DIV_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] sh_data;
  logic [N_DIGITS-1:0]   sh_pts;
  logic [N_DIGITS-1:0]   sh_blank;

  logic [N_DIGITS-1:0]   lz_c;
  logic [3:0]            nib_c;
  logic                  pt_c;
  logic                  bl_c;
  logic [6:0]            gl_c;
  logic [6:0]            seg_c;
  logic [N_DIGITS-1:0]   an_c;

  // Glyph as an a..g string (a in the MSB), active-low.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

`ifdef SEG_LZ_BLANK_EN
  // A digit is suppressed while it and every digit above it is a bare zero.
  always_comb begin
    logic run;
    run  = 1'b1;
    lz_c = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      run     = run & (sh_data[4*i +: 4] == 4'h0) & ~sh_pts[i];
      lz_c[i] = run;
    end
  end
`else
  assign lz_c = '0;
`endif

  // Select the current digit and build the next seg/an values.
  always_comb begin
    nib_c = 4'h0;
    pt_c  = 1'b0;
    bl_c  = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (idx == IDX_W'(i)) begin
        nib_c = sh_data[4*i +: 4];
        pt_c  = sh_pts[i];
        bl_c  = sh_blank[i] | lz_c[i];
      end
    end
    gl_c = glyph(nib_c);
    for (int k = 0; k < 7; k++) begin
      seg_c[k] = bl_c | gl_c[6-k];
    end
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      an_c[i] = (idx != IDX_W'(i));
    end
    if (div_cnt == DIV_LAST) begin
      an_c = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      idx      <= '0;
      sh_data  <= '0;
      sh_pts   <= '0;
      sh_blank <= '0;
      seg      <= 8'hFF;
      an       <= '1;
    end else begin
      if (load) begin
        sh_data  <= data;
        sh_pts   <= points;
        sh_blank <= blank;
      end
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      seg <= {~pt_c, seg_c};
      an  <= an_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (N_DIGITS=4, SCAN_DIV=4): fixed vectors, corner sequences
// and random traffic against a cycle-count based reference model.
module tb_seg_scan_driver;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic [3:0]  points;
  logic [3:0]  blank;
  logic [7:0]  seg;
  logic [3:0]  an;

  seg_scan_driver #(.N_DIGITS(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data),
    .points(points), .blank(blank), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: cycles since reset release plus the latched display copy.
  int          m_t;
  logic [15:0] m_data;
  logic [3:0]  m_pts;
  logic [3:0]  m_blank;
  logic [6:0]  gstr [16];

  typedef struct {
    logic        ld;
    logic [15:0] d;
    logic [7:0]  seg;
    logic [3:0]  an;
  } vec_t;
  vec_t tbl [17];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic model_out(output logic [7:0] s, output logic [3:0] a);
    int   di, dv, top;
    logic [3:0] nib;
    logic [6:0] g;
    logic       bl;
    di = (m_t / 4) % 4;
    dv = m_t % 4;
    top = 0;
    for (int i = 0; i < 4; i++)
      if (m_data[4*i +: 4] != 4'h0 || m_pts[i]) top = i;
    nib = m_data[4*di +: 4];
    g = gstr[nib];
    bl = m_blank[di];
`ifdef SEG_LZ_BLANK_EN
    if (di > top) bl = 1'b1;
`endif
    for (int k = 0; k < 7; k++) s[k] = bl ? 1'b1 : g[6-k];
    s[7] = ~m_pts[di];
    a = (dv == 3) ? 4'hF : ~(4'b0001 << di);
  endtask

  task automatic step(input logic r, input logic l, input logic [15:0] d,
                      input logic [3:0] p, input logic [3:0] b);
    logic [7:0] es;
    logic [3:0] ea;
    rst = r; load = l; data = d; points = p; blank = b;
    if (r) begin
      es = 8'hFF; ea = 4'hF;
      m_t = 0; m_data = '0; m_pts = '0; m_blank = '0;
    end else begin
      model_out(es, ea);
      if (l) begin m_data = d; m_pts = p; m_blank = b; end
      m_t++;
    end
    @(posedge clk); #1;
    check("model_seg", seg, es);
    check("model_an", {4'h0, an}, {4'h0, ea});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("async_rst_seg", seg, 8'hFF);
    check("async_rst_an", {4'h0, an}, 8'h0F);
    step(1, 0, 16'h0, 4'h0, 4'h0);
    step(1, 0, 16'h0, 4'h0, 4'h0);
  endtask

  initial begin
    gstr = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    tbl[0]  = '{1'b1, 16'h1234, 8'hC0, 4'hE};
    tbl[1]  = '{1'b0, 16'hFFFF, 8'h99, 4'hE};
    tbl[2]  = '{1'b0, 16'hFFFF, 8'h99, 4'hE};
    tbl[3]  = '{1'b0, 16'hFFFF, 8'h99, 4'hF};
    tbl[4]  = '{1'b0, 16'hFFFF, 8'hB0, 4'hD};
    tbl[5]  = '{1'b0, 16'hFFFF, 8'hB0, 4'hD};
    tbl[6]  = '{1'b0, 16'hFFFF, 8'hB0, 4'hD};
    tbl[7]  = '{1'b0, 16'hFFFF, 8'hB0, 4'hF};
    tbl[8]  = '{1'b0, 16'hFFFF, 8'hA4, 4'hB};
    tbl[9]  = '{1'b0, 16'hFFFF, 8'hA4, 4'hB};
    tbl[10] = '{1'b0, 16'hFFFF, 8'hA4, 4'hB};
    tbl[11] = '{1'b0, 16'hFFFF, 8'hA4, 4'hF};
    tbl[12] = '{1'b0, 16'hFFFF, 8'hF9, 4'h7};
    tbl[13] = '{1'b0, 16'hFFFF, 8'hF9, 4'h7};
    tbl[14] = '{1'b0, 16'hFFFF, 8'hF9, 4'h7};
    tbl[15] = '{1'b0, 16'hFFFF, 8'hF9, 4'hF};
    tbl[16] = '{1'b0, 16'hFFFF, 8'h99, 4'hE};

    clk = 1'b0; rst = 1'b0; load = 1'b0; data = '0; points = '0; blank = '0;
    m_t = 0; m_data = '0; m_pts = '0; m_blank = '0;
    #2;
    do_reset();

    // Scan order with shadow hold, then reset mid-scan.
    for (int i = 0; i < 17; i++) begin
      step(0, tbl[i].ld, tbl[i].d, 4'h0, 4'h0);
      check("tbl_seg", seg, tbl[i].seg);
      check("tbl_an", {4'h0, an}, {4'h0, tbl[i].an});
    end
    step(0, 0, 16'h0, 4'h0, 4'h0);
    do_reset();
    step(0, 0, 16'h0, 4'h0, 4'h0);
    check("post_rst_seg", seg, 8'hC0);
    check("post_rst_an", {4'h0, an}, 8'h0E);

    // Hex glyphs and a single decimal point.
    do_reset();
    for (int t = 0; t < 16; t++) begin
      step(0, t == 0, 16'hABCF, 4'b0100, 4'h0);
      if (t == 1)  begin check("hex_F_seg", seg, 8'h8E); check("hex_F_an", {4'h0, an}, 8'h0E); end
      if (t == 5)  begin check("hex_C_seg", seg, 8'hC6); check("hex_C_an", {4'h0, an}, 8'h0D); end
      if (t == 9)  begin check("pt_b_seg", seg, 8'h03);  check("pt_b_an", {4'h0, an}, 8'h0B); end
      if (t == 13) begin check("hex_A_seg", seg, 8'h88); check("hex_A_an", {4'h0, an}, 8'h07); end
    end

    // Explicit blank survives live data changes without load.
    do_reset();
    for (int t = 0; t < 16; t++) begin
      step(0, t == 0, (t == 0) ? 16'h1234 : 16'h8888, 4'h0, 4'b1000);
      if (t == 9)  check("hold_d2_seg", seg, 8'hA4);
      if (t == 13) check("blank_d3_seg", seg, 8'hFF);
    end

    // Load on the same edge as a digit advance.
    do_reset();
    for (int t = 0; t < 3; t++) step(0, 0, 16'h0, 4'h0, 4'h0);
    step(0, 1, 16'h5555, 4'h0, 4'h0);
    check("coll_dead_an", {4'h0, an}, 8'h0F);
    check("coll_dead_seg", seg, 8'hC0);
    step(0, 0, 16'h0, 4'h0, 4'h0);
    check("coll_new_an", {4'h0, an}, 8'h0D);
    check("coll_new_seg", seg, 8'h92);

    // Leading zeros.
    do_reset();
    for (int t = 0; t < 18; t++) begin
      step(0, t == 0, 16'h0070, 4'h0, 4'h0);
`ifdef SEG_LZ_BLANK_EN
      if (t == 9)  check("lz_d2_seg", seg, 8'hFF);
      if (t == 13) check("lz_d3_seg", seg, 8'hFF);
`else
      if (t == 9)  check("lz_d2_seg", seg, 8'hC0);
      if (t == 13) check("lz_d3_seg", seg, 8'hC0);
`endif
      if (t == 5)  check("lz_d1_seg", seg, 8'hF8);
      if (t == 17) check("lz_d0_seg", seg, 8'hC0);
    end

    // Random traffic, including sparse-data patterns and occasional resets.
    for (int n = 0; n < 500; n++) begin
      logic [15:0] rd;
      rd = 16'($urandom);
      if ($urandom_range(0, 1) == 0) rd = rd & 16'h00F0;
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, rd,
           4'($urandom_range(0, 3) == 0 ? $urandom : 0), 4'($urandom_range(0, 2) == 0 ? $urandom : 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for a common-anode multi-digit 7-segment display. Latches an N-digit hex value with per-digit decimal point and per-digit blank, then scans the digits one at a time through a shared active-low segment bus and active-low anode selects. Sits between core logic and board display pins; it is the multi-digit, registered successor to the single-digit combinational segment decoder.

## Interface
- `N_DIGITS`, 4: number of digits scanned (1..8).
- `SCAN_DIV`, 100000: clk cycles each digit slot lasts (>= 2).
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load` in 1: capture `data`, `points`, `blank` into shadow registers on this edge.
- `data` in 4*N_DIGITS: hex nibbles; digit i = `data[4i+3:4i]`, digit 0 rightmost.
- `points` in N_DIGITS: decimal point per digit, 1 = lit.
- `blank` in N_DIGITS: 1 = digit i shows nothing (a..g off).
- `seg` out 8: registered, active-low; `seg[0..6]` = a..g, `seg[7]` = p.
- `an` out N_DIGITS: registered, active-low anode select, at most one bit 0.

## Operation
- Shadow registers (`sh_data`, `sh_pts`, `sh_blank`) update only when `load`=1; display always reflects the shadow copy, never the live inputs.
- Prescaler `div_cnt` counts 0..SCAN_DIV-1 and wraps; digit index `idx` increments when `div_cnt`=SCAN_DIV-1, wrapping N_DIGITS-1 -> 0.
- Glyphs, active-low a..g, MSB=a: 0 0000001, 1 1001111, 2 0010010, 3 0000110, 4 1001100, 5 0100100, 6 0100000, 7 0001111, 8 0000000, 9 0000100, A 0001000, b 1100000, C 0110001, d 1000010, E 0110000, F 0111000.
- `seg[6:0]` = glyph of `sh_data[idx]`, or 1111111 when `sh_blank[idx]`=1.
- `seg[7]` = ~`sh_pts[idx]` (active-low, independent of blank).
- `an` = ~(1 << idx), except during dead time.
- Dead time: on the cycle where `div_cnt`=SCAN_DIV-1, the registered `an` is all ones; this suppresses ghosting at digit changes.

## Timing
- Reset (asynchronous): `div_cnt`=0, `idx`=0, all shadows 0, `seg`=8'hFF, `an`=all ones.
- Output latency: `seg`/`an` register the combinational value of the current `idx`/`div_cnt`/shadow, so outputs lag internal state by 1 cycle.
- Load latency: `load` at edge k -> shadow valid after edge k -> first visible in `seg` after edge k+1.
- `load` coinciding with a digit advance: new digit shows new shadow data (both visible after edge k+1).
- Per-digit period is SCAN_DIV cycles: SCAN_DIV-1 cycles lit, 1 dead cycle; full frame is N_DIGITS*SCAN_DIV cycles.
- `load` held high: shadow tracks inputs every cycle, with no glitch beyond the 2-cycle path.
- Reset mid-scan: all state returns to reset values immediately; scanning restarts at digit 0 after release with a full SCAN_DIV slot.
- N_DIGITS=1: `idx` stays 0 and `an` toggles only for dead time.

## Configuration
- `SEG_LZ_BLANK_EN` defined: leading-zero suppression. Digit i (i>0) is treated as blank if `sh_data` nibble is 0 and `sh_pts` bit is 0 for digit i and every digit above it. Digit 0 is never suppressed. Explicit `blank` still applies. Decimal point behaviour is unchanged.
- Undefined: every digit displays its nibble unless `blank` is set; no extra logic is generated.

## Test plan
All scenarios use N_DIGITS=4 and SCAN_DIV=4.
- Reset: assert `rst` mid-scan -> `seg`=8'hFF and `an`=4'b1111 immediately; after release, the first lit digit is `an`=4'b1110 with glyph of 0 (`seg`=8'b1_1000000 read p,g..a).
- Scan order: `load` `data`=16'h1234, `points`=0, `blank`=0 -> `an` sequence 1110, 1101, 1011, 0111, each lit 3 cycles with a 1111 dead cycle between; `seg` shows 4, 3, 2, 1 glyphs.
- Hex and points: `load` `data`=16'hABCF, `points`=4'b0100 -> digit 2 shows glyph B with `seg[7]`=0, while the other digits have `seg[7]`=1.
- Blank and shadow hold: `load` with `blank`=4'b1000, then change `data` without `load` -> digit 3 `seg[6:0]`=7'h7F and the other digits are unchanged.
- Load/advance collision: pulse `load` with 16'h5555 on the `div_cnt`=3 edge -> the next digit appears with glyph 5 two edges later.
- With `SEG_LZ_BLANK_EN` and `data`=16'h0070 -> digits 3 and 2 are blank, digit 1 shows 7, digit 0 shows 0. The same stimulus without the macro shows 0, 0, 7, 0.
